// File: rtl/lsu_l1d_responder.sv
// L1D stand-in for the load/store unit: word memory plus an in-order,
// fixed-latency tagged response FIFO.
module lsu_l1d_responder #(
  parameter int TAG_WIDTH  = 4,
  parameter int MEM_WORDS  = 64,
  parameter int LATENCY    = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  input  logic                 lsu_valid_in,
  output logic                 lsu_ready_out,
  input  logic [63:0]          lsu_addr_in,
  input  logic [63:0]          lsu_value_in,
  input  logic                 lsu_we_in,
  input  logic [TAG_WIDTH-1:0] lsu_tag_in,
  output logic                 resp_valid_out,
  input  logic                 resp_ready_in,
  output logic [63:0]          resp_value_out,
  output logic [TAG_WIDTH-1:0] resp_tag_out,
  output logic                 resp_write_complete_out,
  output logic                 resp_tag_complete_out
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);
  localparam logic [DW-1:0] LAT_C   = DW'(LATENCY);

  logic [63:0]          mem_reg  [MEM_WORDS];
  logic [TAG_WIDTH-1:0] tag_reg  [RESP_DEPTH];
  logic [63:0]          data_reg [RESP_DEPTH];
  logic                 we_reg   [RESP_DEPTH];
  logic [DW-1:0]        cd_reg   [RESP_DEPTH];
  logic [DW-1:0]        cd_next  [RESP_DEPTH];
  logic                 vld_reg  [RESP_DEPTH];
  logic                 vld_next [RESP_DEPTH];

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          ready_en_reg;
  logic [AW-1:0] word_idx;
  logic          push;
  logic          pop;
  logic          addr_unused;

  assign word_idx    = lsu_addr_in[3 +: AW];
  assign addr_unused = ^{lsu_addr_in[63:3+AW], lsu_addr_in[2:0]};

  // ready_en_reg keeps ready low during reset and for the release cycle
  assign lsu_ready_out  = ready_en_reg && (count_reg < DEPTH_C);
  assign push           = lsu_valid_in && lsu_ready_out;
  assign resp_valid_out = (count_reg != '0) && vld_reg[rd_ptr_reg] && (cd_reg[rd_ptr_reg] == '0);
  assign pop            = resp_valid_out && resp_ready_in;

  assign resp_tag_complete_out   = resp_valid_out;
  assign resp_value_out          = resp_valid_out ? data_reg[rd_ptr_reg] : '0;
  assign resp_tag_out            = resp_valid_out ? tag_reg[rd_ptr_reg] : '0;
  assign resp_write_complete_out = resp_valid_out && we_reg[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Countdown starts at LATENCY so the entry surfaces exactly LATENCY edges after acceptance
  for (genvar gi = 0; gi < RESP_DEPTH; gi++) begin : g_slot
    always_comb begin
      cd_next[gi]  = cd_reg[gi];
      vld_next[gi] = vld_reg[gi];
      if (push && (wr_ptr_reg == PW'(gi))) begin
        cd_next[gi]  = LAT_C;
        vld_next[gi] = 1'b1;
      end else begin
        if (pop && (rd_ptr_reg == PW'(gi)))
          vld_next[gi] = 1'b0;
        if (vld_reg[gi] && (cd_reg[gi] != '0))
          cd_next[gi] = cd_reg[gi] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int i = 0; i < MEM_WORDS; i++)
        mem_reg[i] <= '0;
    end else if (push && lsu_we_in) begin
      mem_reg[word_idx] <= lsu_value_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        tag_reg[i]  <= '0;
        data_reg[i] <= '0;
        we_reg[i]   <= 1'b0;
        cd_reg[i]   <= '0;
        vld_reg[i]  <= 1'b0;
      end
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        cd_reg[i]  <= cd_next[i];
        vld_reg[i] <= vld_next[i];
      end
      // Loads capture the pre-write memory word; stores complete with zero data
      if (push) begin
        tag_reg[wr_ptr_reg]  <= lsu_tag_in;
        data_reg[wr_ptr_reg] <= lsu_we_in ? 64'd0 : mem_reg[word_idx];
        we_reg[wr_ptr_reg]   <= lsu_we_in;
        wr_ptr_reg           <= wr_ptr_reg + 1'b1;
      end
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_lsu_l1d_responder.sv
// Randomized and directed bench for lsu_l1d_responder against a queue-based
// transaction model of memory and in-order fixed-latency completions.
module tb_lsu_l1d_responder;

  localparam int TW    = 4;
  localparam int WORDS = 64;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lsu_valid = 1'b0;
  logic          lsu_ready;
  logic [63:0]   lsu_addr = '0;
  logic [63:0]   lsu_value = '0;
  logic          lsu_we = 1'b0;
  logic [TW-1:0] lsu_tag = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [63:0]   resp_value;
  logic [TW-1:0] resp_tag;
  logic          resp_wc;
  logic          resp_tc;

  lsu_l1d_responder #(
    .TAG_WIDTH(TW), .MEM_WORDS(WORDS), .LATENCY(LAT), .RESP_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk),
    .rst_N_in(rst_n),
    .lsu_valid_in(lsu_valid),
    .lsu_ready_out(lsu_ready),
    .lsu_addr_in(lsu_addr),
    .lsu_value_in(lsu_value),
    .lsu_we_in(lsu_we),
    .lsu_tag_in(lsu_tag),
    .resp_valid_out(resp_valid),
    .resp_ready_in(resp_ready),
    .resp_value_out(resp_value),
    .resp_tag_out(resp_tag),
    .resp_write_complete_out(resp_wc),
    .resp_tag_complete_out(resp_tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [63:0]   data;
    bit            we;
    int            due;
  } resp_t;

  resp_t       exp_q[$];
  logic [63:0] model_mem [WORDS];
  bit          model_en;
  int          cyc;
  int          n_cmp;
  int          n_bad;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, want);
    end
  endtask

  function automatic bit model_valid();
    return (exp_q.size() > 0) && (exp_q[0].due <= cyc);
  endfunction

  task automatic check_outputs();
    bit v;
    v = model_valid();
    check_eq("lsu_ready", {63'd0, lsu_ready}, {63'd0, model_en && (exp_q.size() < DEPTH)});
    check_eq("resp_valid", {63'd0, resp_valid}, {63'd0, v});
    check_eq("tag_complete", {63'd0, resp_tc}, {63'd0, v});
    if (v) begin
      check_eq("resp_tag", {60'd0, resp_tag}, {60'd0, exp_q[0].tag});
      check_eq("resp_value", resp_value, exp_q[0].data);
      check_eq("write_complete", {63'd0, resp_wc}, {63'd0, exp_q[0].we});
    end
  endtask

  // One clock: drive at the falling edge, update model at the rising edge, check at the next falling edge
  task automatic step(input bit v, input bit we, input logic [63:0] addr,
                      input logic [63:0] val, input logic [TW-1:0] tag, input bit rr);
    bit    acc;
    bit    pop;
    int    idx;
    resp_t e;
    lsu_valid  = v;
    lsu_we     = we;
    lsu_addr   = addr;
    lsu_value  = val;
    lsu_tag    = tag;
    resp_ready = rr;
    acc = v && model_en && (exp_q.size() < DEPTH);
    pop = model_valid() && rr;
    @(posedge clk);
    cyc++;
    if (pop) void'(exp_q.pop_front());
    model_en = 1'b1;
    if (acc) begin
      idx    = int'((addr >> 3) % WORDS);
      e.tag  = tag;
      e.we   = we;
      e.due  = cyc + LAT;
      e.data = we ? 64'd0 : model_mem[idx];
      if (we) model_mem[idx] = val;
      exp_q.push_back(e);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'd0, 64'd0, '0, rr);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    lsu_valid = 1'b0;
    #1;
    check_eq("rst_ready", {63'd0, lsu_ready}, 64'd0);
    check_eq("rst_valid", {63'd0, resp_valid}, 64'd0);
    check_eq("rst_value", resp_value, 64'd0);
    check_eq("rst_tag", {60'd0, resp_tag}, 64'd0);
    check_eq("rst_wc", {63'd0, resp_wc}, 64'd0);
    check_eq("rst_tc", {63'd0, resp_tc}, 64'd0);
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) model_mem[i] = 64'd0;
    model_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    @(negedge clk);
    do_reset();
    idle(2, 1'b1);

    // Store completion latency
    step(1'b1, 1'b1, 64'hA000, 64'hDEADBEEF, 4'd1, 1'b1);
    idle(6, 1'b1);

    // Store then load same word via a different byte offset
    step(1'b1, 1'b1, 64'hB000, 64'h12345678, 4'd7, 1'b1);
    step(1'b1, 1'b0, 64'hB004, 64'hFFFF, 4'd2, 1'b1);
    idle(8, 1'b1);

    // Backpressure: fill the FIFO, hold the head, then drain
    for (int t = 3; t <= 7; t++) step(1'b1, 1'b0, 64'h40 + 64'(t * 8), 64'd0, 4'(t), 1'b0);
    idle(20, 1'b0);
    idle(6, 1'b1);

    // Address wrap and untouched word
    step(1'b1, 1'b1, 64'h0, 64'hCAFE, 4'd8, 1'b1);
    step(1'b1, 1'b0, 64'h200, 64'd0, 4'd9, 1'b1);
    step(1'b1, 1'b0, 64'h1F8, 64'd0, 4'd10, 1'b1);
    idle(8, 1'b1);

    // Reset with requests in flight
    step(1'b1, 1'b1, 64'h88, 64'h5555, 4'd11, 1'b1);
    idle(6, 1'b1);
    step(1'b1, 1'b0, 64'h88, 64'd0, 4'd12, 1'b1);
    step(1'b1, 1'b1, 64'h90, 64'h77, 4'd13, 1'b1);
    do_reset();
    idle(6, 1'b1);
    step(1'b1, 1'b0, 64'h88, 64'd0, 4'd14, 1'b1);
    idle(6, 1'b1);

    // Full FIFO with a request every cycle
    for (int t = 0; t < 4; t++) step(1'b1, 1'b0, 64'(t * 8), 64'd0, 4'(t), 1'b0);
    idle(5, 1'b0);
    for (int t = 4; t < 20; t++) step(1'b1, 1'b0, 64'(t * 8), 64'd0, 4'(t), 1'b1);
    idle(8, 1'b1);

    // Randomized traffic over a small set of hot words with random upper address bits
    for (int i = 0; i < 1500; i++) begin
      a = {$urandom, 23'($urandom), 6'($urandom_range(0, 7)), 3'($urandom)};
      d = {$urandom, $urandom};
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom), a, d, 4'($urandom),
             $urandom_range(0, 3) != 0);
      end
    end
    idle(12, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
